// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C master controller.
//   cmd_op_e   : host command encoding (START, STOP, WRITE, READ)
//   state_e    : controller FSM states
//   I2C_CLK_DIV_DEFAULT : default clk cycles per SCL quarter-period
package i2c_pkg;

  localparam int unsigned I2C_CLK_DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_STOP  = 2'b01,
    OP_WRITE = 2'b10,
    OP_READ  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_STOP
  } state_e;

endpackage

// File: rtl/i2c_clk_div.sv
// i2c_clk_div: quarter-period timer for the I2C master.
//   clk, reset   : block clock, synchronous active-high reset
//   restart      : force counter and quarter index back to 0
//   hold         : freeze the counter (clock stretching)
//   qtick        : high on the last cycle of the current quarter
//   quarter      : current quarter index Q0..Q3
//   quarter_nxt  : quarter index that will be current after this edge
module i2c_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       hold,
  output logic       qtick,
  output logic [1:0] quarter,
  output logic [1:0] quarter_nxt
);

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  quarter_q, quarter_d;

  always_comb begin
    qtick     = (cnt_q == LAST) && !hold;
    cnt_d     = cnt_q;
    quarter_d = quarter_q;
    if (restart) begin
      cnt_d     = '0;
      quarter_d = '0;
    end else if (!hold) begin
      if (qtick) begin
        cnt_d     = '0;
        quarter_d = quarter_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      quarter_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      quarter_q <= quarter_d;
    end
  end

  assign quarter     = quarter_q;
  assign quarter_nxt = quarter_d;

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: byte-level I2C master (START / STOP / WRITE / READ).
//   cmd_valid/cmd_ready/cmd_op/cmd_data/cmd_nack : host command handshake
//   rsp_valid/rsp_data/rsp_nack                  : completion pulse and results
//   busy                                         : command in progress
//   scl_in/sda_in, scl_out/sda_out               : resolved levels / open-drain drive
// Optional macro I2C_MASTER_CLK_STRETCH_EN: freeze the quarter timer in Q2
// while the master releases SCL but the bus still reads low.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = I2C_CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       busy,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       sda_out
);

  state_e      state_q, state_d;
  cmd_op_e     op_q, op_d;
  logic [7:0]  data_q, data_d;
  logic        nack_q, nack_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  rx_q, rx_d;
  logic        ack_q, ack_d;
  logic        scl_out_q, scl_out_d;
  logic        sda_out_q, sda_out_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_nack_q, rsp_nack_d;

  logic        qtick;
  logic [1:0]  quarter, quarter_nxt;
  logic        restart, hold;

  assign restart = (state_q == ST_IDLE);

`ifdef I2C_MASTER_CLK_STRETCH_EN
  assign hold = (state_q != ST_IDLE) && (quarter == 2'd2) && scl_out_q && !scl_in;
`else
  logic scl_in_unused;
  assign scl_in_unused = scl_in;
  assign hold          = 1'b0;
`endif

  i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .hold        (hold),
    .qtick       (qtick),
    .quarter     (quarter),
    .quarter_nxt (quarter_nxt)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    nack_d      = nack_q;
    bit_d       = bit_q;
    rx_d        = rx_q;
    ack_d       = ack_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_nack_d  = rsp_nack_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d   = cmd_op_e'(cmd_op);
          data_d = cmd_data;
          nack_d = cmd_nack;
          bit_d  = '0;
          case (cmd_op_e'(cmd_op))
            OP_START: state_d = ST_START;
            OP_STOP:  state_d = ST_STOP;
            default:  state_d = ST_BIT;
          endcase
        end
      end
      ST_START, ST_STOP: begin
        if (qtick && quarter == 2'd3) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
        end
      end
      ST_BIT: begin
        if (qtick && quarter == 2'd2) begin
          if (bit_q == 4'd8) ack_d = sda_in;
          else               rx_d  = {rx_q[6:0], sda_in};
        end
        if (qtick && quarter == 2'd3) begin
          if (bit_q == 4'd8) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            if (op_q == OP_READ) rsp_data_d = rx_q;
            else                 rsp_nack_d = ack_q;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus drive is computed from the post-edge state/quarter so the
    // registered pins change on the first cycle of the quarter they describe.
    scl_out_d = 1'b1;
    sda_out_d = 1'b1;
    case (state_d)
      ST_START: begin
        scl_out_d = (quarter_nxt != 2'd3);
        sda_out_d = !quarter_nxt[1];
      end
      ST_STOP: begin
        scl_out_d = (quarter_nxt != 2'd0);
        sda_out_d = (quarter_nxt == 2'd3);
      end
      ST_BIT: begin
        scl_out_d = quarter_nxt[1];
        if (bit_d == 4'd8) sda_out_d = (op_d == OP_READ) ? nack_d : 1'b1;
        else               sda_out_d = (op_d == OP_WRITE) ? data_d[~bit_d[2:0]] : 1'b1;
      end
      default: ;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_START;
      data_q      <= '0;
      nack_q      <= 1'b0;
      bit_q       <= '0;
      rx_q        <= '0;
      ack_q       <= 1'b0;
      scl_out_q   <= 1'b1;
      sda_out_q   <= 1'b1;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_nack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      nack_q      <= nack_d;
      bit_q       <= bit_d;
      rx_q        <= rx_d;
      ack_q       <= ack_d;
      scl_out_q   <= scl_out_d;
      sda_out_q   <= sda_out_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_nack_q  <= rsp_nack_d;
    end
  end

  assign scl_out   = scl_out_q;
  assign sda_out   = sda_out_q;
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_nack  = rsp_nack_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed self-checking bench for i2c_master_ctrl.
// A cycle-offset model predicts SCL/SDA/busy/ready/rsp_valid for every
// cycle of an active command; literal checks pin latencies and results.
module tb_i2c_master_ctrl;

  localparam int CD = 4;
  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_nack;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       busy;
  logic       scl_in, sda_in, scl_out, sda_out;

  logic       slave_sda = 1'b1;
  logic       scl_hold_n = 1'b1;
  assign sda_in = sda_out & slave_sda;
  assign scl_in = scl_out & scl_hold_n;

  i2c_master_ctrl #(.CLK_DIV(CD)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_nack  (cmd_nack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_nack  (rsp_nack),
    .busy      (busy),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_out   (scl_out),
    .sda_out   (sda_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc = 0;

  // Model of the command in flight.
  logic       m_active = 1'b0;
  logic       chk_wave = 1'b1;
  logic [1:0] m_op;
  logic [7:0] m_data;
  logic       m_nack;
  logic       slave_ack = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] cap;
  int         nine_low;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave: shifts out slave_byte during a READ, ACKs the 9th bit of a WRITE.
  always @(posedge clk) begin
    int t, b;
    #2;
    slave_sda = 1'b1;
    if (m_active) begin
      t = cyc - acc;
      b = t / (4 * CD);
      if (m_op == C_READ && b < 8)                      slave_sda = slave_byte[7 - b];
      else if (m_op == C_WRITE && b == 8 && slave_ack) slave_sda = 1'b0;
    end
  end

  // Per-cycle compare against the offset model.
  always @(negedge clk) begin
    int t, n, q, b;
    logic e_scl, e_sda;
    logic [4:0] exp_v;
    if (m_active && chk_wave) begin
      t = cyc - acc;
      n = (m_op[1]) ? 36 * CD : 4 * CD;
      q = (t / CD) % 4;
      b = t / (4 * CD);
      e_scl = 1'b1;
      e_sda = 1'b1;
      case (m_op)
        C_START: begin e_scl = (q != 3); e_sda = (q < 2); end
        C_STOP:  begin e_scl = (q != 0); e_sda = (q == 3); end
        default: begin
          e_scl = (q >= 2);
          if (b < 8) e_sda = (m_op == C_WRITE) ? m_data[7 - b] : 1'b1;
          else       e_sda = (m_op == C_READ) ? m_nack : 1'b1;
        end
      endcase
      if (t < n)       exp_v = {e_scl, e_sda, 1'b1, 1'b0, 1'b0};
      else if (t == n) exp_v = 5'b11011;
      else             exp_v = 5'b11010;
      chk("wave{scl,sda,busy,ready,rsp_valid}",
          {27'd0, scl_out, sda_out, busy, cmd_ready, rsp_valid}, {27'd0, exp_v});
      if (t < n && m_op[1] && q == 2 && b < 8) cap[7 - b] = sda_out;
      if (t < n && m_op == C_READ && b == 8 && !sda_out) nine_low++;
      if (t == n && m_op == C_WRITE) chk("model_rsp_nack", {31'd0, rsp_nack}, {31'd0, !slave_ack});
      if (t == n && m_op == C_READ)  chk("model_rsp_data", {24'd0, rsp_data}, {24'd0, slave_byte});
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic n);
    for (int unsigned i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
    chk("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    cmd_op    = op;
    cmd_data  = d;
    cmd_nack  = n;
    cmd_valid = 1'b1;
    m_op      = op;
    m_data    = d;
    m_nack    = n;
    cap       = 8'h00;
    nine_low  = 0;
    @(posedge clk);
    #1;
    acc       = cyc;
    m_active  = 1'b1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int unsigned i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) begin
        lat = cyc - acc;
        break;
      end
    end
    m_active = 1'b0;
  endtask

  initial begin
    int lat, rv_count, t;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    cmd_nack  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_scl_out",   {31'd0, scl_out},   32'd1);
    chk("rst_sda_out",   {31'd0, sda_out},   32'd1);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data",  {24'd0, rsp_data},  32'd0);
    chk("rst_rsp_nack",  {31'd0, rsp_nack},  32'd0);
    reset = 1'b0;
    @(negedge clk);

    // START
    issue(C_START, 8'h00, 1'b0);
    wait_done(lat);
    chk("start_latency", lat, 16);

    // WRITE 0xA5 with ACK
    slave_ack = 1'b1;
    issue(C_WRITE, 8'hA5, 1'b0);
    wait_done(lat);
    chk("write_ack_latency", lat, 144);
    chk("write_ack_sda_bits", {24'd0, cap}, 32'h0000_00A5);
    chk("write_ack_rsp_nack", {31'd0, rsp_nack}, 32'd0);

    // WRITE 0x50 with nobody answering
    slave_ack = 1'b0;
    issue(C_WRITE, 8'h50, 1'b0);
    wait_done(lat);
    chk("write_noslave_latency", lat, 144);
    chk("write_noslave_rsp_nack", {31'd0, rsp_nack}, 32'd1);

    // READ 0x3C, master NACKs
    slave_byte = 8'h3C;
    issue(C_READ, 8'h00, 1'b1);
    wait_done(lat);
    chk("read_nack_latency", lat, 144);
    chk("read_nack_rsp_data", {24'd0, rsp_data}, 32'h3C);
    chk("read_nack_sda_low_9th", nine_low, 0);
    chk("read_keeps_rsp_nack", {31'd0, rsp_nack}, 32'd1);

    // READ 0xC3, master ACKs: SDA low for all of the 9th bit
    slave_byte = 8'hC3;
    issue(C_READ, 8'h00, 1'b0);
    wait_done(lat);
    chk("read_ack_rsp_data", {24'd0, rsp_data}, 32'hC3);
    chk("read_ack_sda_low_9th", nine_low, 4 * CD);

    // WRITE must not disturb rsp_data
    slave_ack = 1'b1;
    issue(C_WRITE, 8'h01, 1'b0);
    wait_done(lat);
    chk("write_keeps_rsp_data", {24'd0, rsp_data}, 32'hC3);
    chk("write_01_rsp_nack", {31'd0, rsp_nack}, 32'd0);

    // STOP
    issue(C_STOP, 8'h00, 1'b0);
    wait_done(lat);
    chk("stop_latency", lat, 16);
    @(negedge clk);
    chk("stop_bus_released", {30'd0, scl_out, sda_out}, 32'd3);

    // Clock stretch: scl_in low 20 cycles starting at bit 3 Q2
    slave_ack = 1'b0;
`ifdef I2C_MASTER_CLK_STRETCH_EN
    chk_wave = 1'b0;
`endif
    fork
      begin
        issue(C_WRITE, 8'hFF, 1'b0);
        wait_done(lat);
      end
      begin
        for (int unsigned i = 0; i < 400 && !(m_active && (cyc - acc) == 3 * 16 + 8); i++)
          @(negedge clk);
        scl_hold_n = 1'b0;
        repeat (20) @(negedge clk);
        scl_hold_n = 1'b1;
      end
    join
    chk_wave = 1'b1;
`ifdef I2C_MASTER_CLK_STRETCH_EN
    chk("stretch_latency", lat, 164);
`else
    chk("stretch_latency", lat, 144);
`endif

    // Reset in the middle of a WRITE (bit 4, Q1: SCL and SDA both low)
    issue(C_WRITE, 8'hA5, 1'b0);
    for (int unsigned i = 0; i < 400; i++) begin
      @(negedge clk);
      t = cyc - acc;
      if (t == 4 * 16 + 5) break;
    end
    chk("midwrite_bus_low_before_reset", {30'd0, scl_out, sda_out}, 32'd0);
    reset    = 1'b1;
    m_active = 1'b0;
    @(negedge clk);
    chk("midwrite_reset_release", {30'd0, scl_out, sda_out}, 32'd3);
    chk("midwrite_reset_idle", {30'd0, busy, cmd_ready}, 32'd1);
    reset    = 1'b0;
    rv_count = 0;
    for (int unsigned i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) rv_count++;
    end
    chk("midwrite_no_rsp_valid", rv_count, 0);
    issue(C_START, 8'h00, 1'b0);
    wait_done(lat);
    chk("start_after_reset_latency", lat, 16);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: clk cycles per SCL quarter-period (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: block clock; all logic on posedge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: host command request.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: controller can accept a command.
REQ-006 The block SHALL have port cmd_op, input, 2 bits: 00 START, 01 STOP, 10 WRITE, 11 READ.
REQ-007 The block SHALL have port cmd_data, input, 8 bits: byte for WRITE.
REQ-008 The block SHALL have port cmd_nack, input, 1 bit: ack bit the master drives after READ (0 ACK, 1 NACK).
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: one-cycle command-complete pulse.
REQ-010 The block SHALL have port rsp_data, output, 8 bits: byte received by READ.
REQ-011 The block SHALL have port rsp_nack, output, 1 bit: ack bit sampled after WRITE (1 = NACK).
REQ-012 The block SHALL have port busy, output, 1 bit: a command is in progress.
REQ-013 The block SHALL have ports scl_in and sda_in, inputs, 1 bit each: resolved bus levels.
REQ-014 The block SHALL have ports scl_out and sda_out, outputs, 1 bit each: open-drain drive; 1 = release, 0 = pull low.

Function
REQ-015 The FSM SHALL have states IDLE, START, BIT, STOP; cmd_ready SHALL be 1 only in IDLE.
REQ-016 A command SHALL be accepted on a cycle with cmd_valid && cmd_ready; cmd_op, cmd_data and cmd_nack SHALL be latched on that cycle; busy SHALL rise on the next cycle.
REQ-017 Each bit/condition SHALL span 4 quarters (Q0..Q3) of CLK_DIV cycles each, timed by a quarter tick.
REQ-018 Data bits: SCL low in Q0/Q1 with SDA updated at Q0 start; SCL released in Q2/Q3; sda_in sampled on the last cycle of Q2.
REQ-019 START: SDA released, SCL released in Q0/Q1; SDA low at Q2; SCL low at Q3.
REQ-020 STOP: SDA low and SCL low in Q0; SCL released at Q1; SDA released at Q3; bus left with both lines released.
REQ-021 WRITE: 8 data bits MSB first (sda_out = bit value), then a 9th bit with SDA released; rsp_nack = sampled 9th bit.
REQ-022 READ: SDA released for 8 bits, sampled MSB first into rsp_data; 9th bit drives cmd_nack.
REQ-023 Latency: START/STOP SHALL take 4*CLK_DIV cycles and WRITE/READ 36*CLK_DIV cycles (no stretching), then rsp_valid for 1 cycle, with IDLE, busy=0 and cmd_ready=1 on the following cycle.
REQ-024 rsp_data and rsp_nack SHALL hold their values until the next rsp_valid.
REQ-025 Command ordering SHALL NOT be checked; WRITE/READ without a prior START SHALL execute as given.

Reset
REQ-026 While reset=1: scl_out=1, sda_out=1, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, rsp_nack=0, FSM=IDLE, and the quarter counter SHALL be 0.
REQ-027 Reset mid-command SHALL abandon the transfer, release both lines on the next clk edge, and issue no rsp_valid.

Configuration
REQ-028 With I2C_MASTER_CLK_STRETCH_EN defined, the quarter counter SHALL freeze in Q2 while scl_out=1 and scl_in=0, and resume when scl_in=1.
REQ-029 Without I2C_MASTER_CLK_STRETCH_EN, scl_in SHALL be ignored and timing SHALL be fixed per REQ-023.

Structure
REQ-030 Package i2c_pkg SHALL hold the cmd_op enum, the FSM state enum, and the default CLK_DIV constant.
REQ-031 Sub-module i2c_clk_div SHALL generate the quarter tick and quarter index, with hold (stretch) and restart inputs.

Verification (CLK_DIV=4)
REQ-032 Reset check: assert reset for 3 cycles -> scl_out=1, sda_out=1, cmd_ready=1, busy=0, rsp_valid=0.
REQ-033 WRITE with ACK: START, then WRITE 0xA5 with sda_in=0 on the 9th bit -> SDA sequence 1,0,1,0,0,1,0,1; rsp_valid exactly 144 cycles after accept; rsp_nack=0.
REQ-034 WRITE with no slave: WRITE 0x50 with sda_in held 1 -> rsp_nack=1.
REQ-035 READ with NACK: READ with cmd_nack=1 and slave driving 0x3C -> rsp_data=0x3C; sda_out=1 throughout the 9th bit.
REQ-036 Clock stretch: scl_in held low 20 cycles in bit 3 Q2 -> completion 164 cycles after accept with I2C_MASTER_CLK_STRETCH_EN defined; 144 cycles without it.
REQ-037 Reset mid-WRITE: reset during bit 4 -> scl_out=sda_out=1 next cycle; no rsp_valid; next START accepted normally.
